iq_power_accumulator: RTL



---
 rtl/iq_power_accumulator_pkg.sv | 10 +
 rtl/iq_square_sum.sv | 38 +++
 rtl/iq_power_accumulator.sv | 86 ++++++++
 3 files changed

// File: rtl/iq_power_accumulator_pkg.sv
// iq_power_accumulator_pkg: shared widths for the I/Q power accumulator and the
// downstream square-root stage (sum width, accumulator width, output fraction bits).
package iq_power_accumulator_pkg;
    localparam int iq_in_w = 16;
    localparam int iq_in_dec = 15;
    localparam int iq_log2n = 4;
    localparam int iq_sum_w = 2 * iq_in_w;
    localparam int iq_acc_w = iq_sum_w + iq_log2n;
    localparam int iq_out_dec = 2 * iq_in_dec;
endpackage

// File: rtl/iq_square_sum.sv
// iq_square_sum: registered I^2 and Q^2 followed by a registered sum, with a valid pipeline.
// Ports: clk, reset (sync, active-high), restart (clears valids), in_valid/in_i/in_q
// sample input; sum_sq/sum_valid the unsigned I^2+Q^2 two cycles later.
module iq_square_sum
    import iq_power_accumulator_pkg::*;
#(
    parameter int inputWidth = iq_in_w
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          restart,
    input  logic                          in_valid,
    input  logic signed [inputWidth-1:0]  in_i,
    input  logic signed [inputWidth-1:0]  in_q,
    output logic [2*inputWidth-1:0]       sum_sq,
    output logic                          sum_valid
);
    logic signed [2*inputWidth-1:0] ext_i, ext_q;
    logic [2*inputWidth-1:0] sq_i, sq_q;
    logic sq_valid;
    // Squares are never negative and peak at 2^(2W-2), so the signed product fits unsigned.
    assign ext_i = in_i;
    assign ext_q = in_q;
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            sq_valid <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            sq_valid <= in_valid;
            sum_valid <= sq_valid;
        end
        if (in_valid) begin
            sq_i <= ext_i * ext_i;
            sq_q <= ext_q * ext_q;
        end
        if (sq_valid) sum_sq <= sq_i + sq_q;
    end
endmodule

// File: rtl/iq_power_accumulator.sv
// iq_power_accumulator: block-averaged I^2+Q^2, one mean-power word per 2^log2Samples samples.
// Ports: clk, reset (sync, active-high), restart (drops the partial block), in_valid/in_i/in_q
// signed samples; power (2*inputWidth bits, 2*inputDecWidth fraction bits), outData_valid
// one-cycle pulse, blockCount samples accumulated in the current block.
// Define IQ_POWER_ROUND_EN for round-half-up averaging (saturating); default truncates.
module iq_power_accumulator
    import iq_power_accumulator_pkg::*;
#(
    parameter int inputWidth = iq_in_w,
    parameter int inputDecWidth = iq_in_dec,
    parameter int log2Samples = iq_log2n
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          restart,
    input  logic                          in_valid,
    input  logic signed [inputWidth-1:0]  in_i,
    input  logic signed [inputWidth-1:0]  in_q,
    output logic [2*inputWidth-1:0]       power,
    output logic                          outData_valid,
    output logic [log2Samples:0]          blockCount
);
    localparam int sum_w = 2 * inputWidth;
    localparam int acc_w = sum_w + log2Samples;
    localparam logic [log2Samples:0] last_cnt = (log2Samples + 1)'((1 << log2Samples) - 1);

    if (log2Samples < 0 || log2Samples > 8 || inputDecWidth >= inputWidth) begin : g_bad_cfg
        $error("iq_power_accumulator: unsupported parameter set");
    end

    logic [sum_w-1:0] sum_sq, power_next;
    logic [acc_w-1:0] acc, acc_next, total;
    logic sum_valid, last, pend;

    iq_square_sum #(.inputWidth(inputWidth)) u_square_sum (
        .clk(clk),
        .reset(reset),
        .restart(restart),
        .in_valid(in_valid),
        .in_i(in_i),
        .in_q(in_q),
        .sum_sq(sum_sq),
        .sum_valid(sum_valid)
    );

    assign acc_next = acc + acc_w'(sum_sq);
    assign last = blockCount == last_cnt;

`ifdef IQ_POWER_ROUND_EN
    localparam logic [acc_w:0] half = (acc_w + 1)'((1 << log2Samples) >> 1);
    logic [acc_w:0] rounded;
    assign rounded = ({1'b0, total} + half) >> log2Samples;
    assign power_next = rounded > (acc_w + 1)'({sum_w{1'b1}}) ? '1 : sum_w'(rounded);
`else
    assign power_next = sum_w'(total >> log2Samples);
`endif

    // Stage 3: the last sample of a block folds straight into the latched total, so the
    // accumulator restarts from zero on the same edge and back-to-back blocks lose nothing.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            acc <= '0;
            blockCount <= '0;
            pend <= 1'b0;
            total <= '0;
        end else begin
            pend <= sum_valid && last;
            if (sum_valid) begin
                acc <= last ? '0 : acc_next;
                blockCount <= last ? '0 : blockCount + 1'b1;
                total <= acc_next;
            end
        end
    end

    // Divide/round stage: restart also cancels a block that is about to be emitted.
    always_ff @(posedge clk) begin
        if (reset) begin
            power <= '0;
            outData_valid <= 1'b0;
        end else begin
            outData_valid <= pend && !restart;
            if (pend && !restart) power <= power_next;
        end
    end
endmodule
